// File: rtl/aclk_counter_if.sv
// Time-of-day bus between the alarm clock control path and aclk_counter.
// ACLK_DAY_TICK_EN adds the day_tick signal to both modports.
interface aclk_counter_if;
  logic       one_minute;
  logic       load_new_c;
  logic [3:0] new_current_time_ms_hr;
  logic [3:0] new_current_time_ls_hr;
  logic [3:0] new_current_time_ms_min;
  logic [3:0] new_current_time_ls_min;
  logic [3:0] current_time_ms_hr;
  logic [3:0] current_time_ls_hr;
  logic [3:0] current_time_ms_min;
  logic [3:0] current_time_ls_min;
  logic       reset_count;
  logic       load_err;
`ifdef ACLK_DAY_TICK_EN
  logic       day_tick;

  modport master (
    output one_minute, load_new_c,
    output new_current_time_ms_hr, new_current_time_ls_hr,
    output new_current_time_ms_min, new_current_time_ls_min,
    input  current_time_ms_hr, current_time_ls_hr,
    input  current_time_ms_min, current_time_ls_min,
    input  reset_count, load_err, day_tick
  );

  modport slave (
    input  one_minute, load_new_c,
    input  new_current_time_ms_hr, new_current_time_ls_hr,
    input  new_current_time_ms_min, new_current_time_ls_min,
    output current_time_ms_hr, current_time_ls_hr,
    output current_time_ms_min, current_time_ls_min,
    output reset_count, load_err, day_tick
  );
`else
  modport master (
    output one_minute, load_new_c,
    output new_current_time_ms_hr, new_current_time_ls_hr,
    output new_current_time_ms_min, new_current_time_ls_min,
    input  current_time_ms_hr, current_time_ls_hr,
    input  current_time_ms_min, current_time_ls_min,
    input  reset_count, load_err
  );

  modport slave (
    input  one_minute, load_new_c,
    input  new_current_time_ms_hr, new_current_time_ls_hr,
    input  new_current_time_ms_min, new_current_time_ls_min,
    output current_time_ms_hr, current_time_ls_hr,
    output current_time_ms_min, current_time_ls_min,
    output reset_count, load_err
  );
`endif
endinterface

// File: rtl/aclk_counter.sv
// 24-hour BCD time-of-day counter (HH:MM) with validated load.
// Optional feature macro: ACLK_DAY_TICK_EN (adds registered day_tick on 23:59 -> 00:00).
module aclk_counter #(
  parameter logic [3:0] RESET_MS_HR  = 4'd0,
  parameter logic [3:0] RESET_LS_HR  = 4'd0,
  parameter logic [3:0] RESET_MS_MIN = 4'd0,
  parameter logic [3:0] RESET_LS_MIN = 4'd0
) (
  input logic           clock,
  input logic           reset,
  aclk_counter_if.slave bus
);

  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic [3:0] inc_ms_hr, inc_ls_hr, inc_ms_min, inc_ls_min;
  logic       reset_count_q, load_err_q;
  logic       load_valid;
  logic       wrap_day;

  assign load_valid = (bus.new_current_time_ms_hr <= 4'd2) &&
                      (bus.new_current_time_ls_hr <= 4'd9) &&
                      !((bus.new_current_time_ms_hr == 4'd2) &&
                        (bus.new_current_time_ls_hr > 4'd3)) &&
                      (bus.new_current_time_ms_min <= 4'd5) &&
                      (bus.new_current_time_ls_min <= 4'd9);

  // Full ripple carry resolved in one cycle so 23:59 rolls straight to 00:00.
  always_comb begin
    inc_ms_hr  = ms_hr;
    inc_ls_hr  = ls_hr;
    inc_ms_min = ms_min;
    inc_ls_min = ls_min;
    wrap_day   = 1'b0;
    if (ls_min == 4'd9) begin
      inc_ls_min = 4'd0;
      if (ms_min == 4'd5) begin
        inc_ms_min = 4'd0;
        if ((ms_hr == 4'd2) && (ls_hr == 4'd3)) begin
          inc_ms_hr = 4'd0;
          inc_ls_hr = 4'd0;
          wrap_day  = 1'b1;
        end else if (ls_hr == 4'd9) begin
          inc_ls_hr = 4'd0;
          inc_ms_hr = ms_hr + 4'd1;
        end else begin
          inc_ls_hr = ls_hr + 4'd1;
        end
      end else begin
        inc_ms_min = ms_min + 4'd1;
      end
    end else begin
      inc_ls_min = ls_min + 4'd1;
    end
  end

  // A load, valid or not, swallows a coincident minute pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      ms_hr         <= RESET_MS_HR;
      ls_hr         <= RESET_LS_HR;
      ms_min        <= RESET_MS_MIN;
      ls_min        <= RESET_LS_MIN;
      reset_count_q <= 1'b0;
      load_err_q    <= 1'b0;
    end else begin
      reset_count_q <= 1'b0;
      load_err_q    <= 1'b0;
      if (bus.load_new_c) begin
        if (load_valid) begin
          ms_hr         <= bus.new_current_time_ms_hr;
          ls_hr         <= bus.new_current_time_ls_hr;
          ms_min        <= bus.new_current_time_ms_min;
          ls_min        <= bus.new_current_time_ls_min;
          reset_count_q <= 1'b1;
        end else begin
          load_err_q    <= 1'b1;
        end
      end else if (bus.one_minute) begin
        ms_hr  <= inc_ms_hr;
        ls_hr  <= inc_ls_hr;
        ms_min <= inc_ms_min;
        ls_min <= inc_ls_min;
      end
    end
  end

`ifdef ACLK_DAY_TICK_EN
  logic day_tick_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      day_tick_q <= 1'b0;
    end else begin
      day_tick_q <= !bus.load_new_c && bus.one_minute && wrap_day;
    end
  end

  assign bus.day_tick = day_tick_q;
`else
  logic unused_wrap_day;
  assign unused_wrap_day = wrap_day;
`endif

  assign bus.current_time_ms_hr  = ms_hr;
  assign bus.current_time_ls_hr  = ls_hr;
  assign bus.current_time_ms_min = ms_min;
  assign bus.current_time_ls_min = ls_min;
  assign bus.reset_count         = reset_count_q;
  assign bus.load_err            = load_err_q;

endmodule

// File: tb/tb_aclk_counter.sv
// Directed bench for aclk_counter; expected values are hand-computed HH:MM constants.
// Day-tick checks are compiled in only when ACLK_DAY_TICK_EN is defined.
module tb_aclk_counter;
  logic clock;
  logic reset;
  int   errors;
  int   checks;

  aclk_counter_if bus ();

  aclk_counter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic rst, input logic load, input logic minute,
                                input logic [15:0] t);
    reset                       = rst;
    bus.load_new_c              = load;
    bus.one_minute              = minute;
    bus.new_current_time_ms_hr  = t[15:12];
    bus.new_current_time_ls_hr  = t[11:8];
    bus.new_current_time_ms_min = t[7:4];
    bus.new_current_time_ls_min = t[3:0];
  endtask

  task automatic check_output(input string tag, input logic [15:0] exp_time,
                              input logic exp_rc, input logic exp_le);
    logic [15:0] obs_time;
    obs_time = {bus.current_time_ms_hr, bus.current_time_ls_hr,
                bus.current_time_ms_min, bus.current_time_ls_min};
    checks++;
    assert (obs_time === exp_time) else begin
      errors++;
      $error("[TB] FAIL %s time: observed=%h expected=%h", tag, obs_time, exp_time);
    end
    checks++;
    assert (bus.reset_count === exp_rc) else begin
      errors++;
      $error("[TB] FAIL %s reset_count: observed=%b expected=%b", tag, bus.reset_count, exp_rc);
    end
    checks++;
    assert (bus.load_err === exp_le) else begin
      errors++;
      $error("[TB] FAIL %s load_err: observed=%b expected=%b", tag, bus.load_err, exp_le);
    end
  endtask

  task automatic check_day_tick(input string tag, input logic exp_dt);
`ifdef ACLK_DAY_TICK_EN
    checks++;
    assert (bus.day_tick === exp_dt) else begin
      errors++;
      $error("[TB] FAIL %s day_tick: observed=%b expected=%b", tag, bus.day_tick, exp_dt);
    end
`else
    if (exp_dt === 1'bx) $display("[TB] %s", tag);
`endif
  endtask

  initial begin
    errors = 0;
    checks = 0;

    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    check_output("reset", 16'h0000, 1'b0, 1'b0);
    check_day_tick("reset", 1'b0);

    // Three minute pulses spaced five cycles apart.
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
      tick();
      apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      check_output("minute_pulse", 16'(i + 1), 1'b0, 1'b0);
      for (int j = 0; j < 4; j++) begin
        tick();
        check_output("minute_idle", 16'(i + 1), 1'b0, 1'b0);
      end
    end

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1959);
    tick();
    check_output("load_1959", 16'h1959, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_output("after_load_1959", 16'h1959, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    check_output("carry_1959_2000", 16'h2000, 1'b0, 1'b0);
    check_day_tick("carry_1959_2000", 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0959);
    tick();
    check_output("load_0959", 16'h0959, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    check_output("carry_0959_1000", 16'h1000, 1'b0, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h2359);
    tick();
    check_output("load_2359", 16'h2359, 1'b1, 1'b0);
    check_day_tick("load_2359", 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    check_output("wrap_2359_0000", 16'h0000, 1'b0, 1'b0);
    check_day_tick("wrap_2359_0000", 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_output("after_wrap", 16'h0000, 1'b0, 1'b0);
    check_day_tick("after_wrap", 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1234);
    tick();
    check_output("load_1234", 16'h1234, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h2400);
    tick();
    check_output("reject_2400", 16'h1234, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_output("after_reject", 16'h1234, 1'b0, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1260);
    tick();
    check_output("reject_1260", 16'h1234, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0A00);
    tick();
    check_output("reject_0A00", 16'h1234, 1'b0, 1'b1);
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h3000);
    tick();
    check_output("reject_with_minute", 16'h1234, 1'b0, 1'b1);

    // Load beats a coincident minute pulse.
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h0815);
    tick();
    check_output("load_with_minute", 16'h0815, 1'b1, 1'b0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    check_output("minute_after_load", 16'h0816, 1'b0, 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    tick();
    check_output("load_0000", 16'h0000, 1'b1, 1'b0);
    check_day_tick("load_0000", 1'b0);

    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1010);
    tick();
    check_output("load_1010", 16'h1010, 1'b1, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, 16'h1111);
    tick();
    check_output("reset_priority", 16'h0000, 1'b0, 1'b0);
    check_day_tick("reset_priority", 1'b0);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1010);
      tick();
      check_output("held_load", 16'h1010, 1'b1, 1'b0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    check_output("held_load_release", 16'h1010, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
